// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with stall watchdog (optional total-stall counter: PIPE_CTRL_STALL_CNT_EN)
module pipe_ctrl #(
  parameter int unsigned STALL_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic        flushreq_i,
  input  logic [31:0] flush_pc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        stall_timeout_o
`ifdef PIPE_CTRL_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] cont_cnt;
  logic        stall_any;
  logic        accept_flush;

  // Next-state and zero-latency stall vector; the deepest stalled stage wins.
  always_comb begin
    next_state = state;
    stall_o    = 6'b000000;
    case (state)
      IDLE:    if (flushreq_i) next_state = FLUSH;
      FLUSH:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (!rst && state == IDLE) begin
      if (stallreq_from_mem)      stall_o = 6'b011111;
      else if (stallreq_from_ex)  stall_o = 6'b001111;
      else if (stallreq_from_id)  stall_o = 6'b000111;
      else                        stall_o = 6'b000000;
    end
  end

  assign stall_any    = (stall_o != 6'b000000);
  assign accept_flush = (state == IDLE) && flushreq_i;
  assign flush_o      = (state == FLUSH);

  // State register; reset also aborts an in-progress flush.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Redirect target is captured only when a flush is accepted and held otherwise.
  always_ff @(posedge clk) begin
    if (rst)               new_pc_o <= 32'd0;
    else if (accept_flush) new_pc_o <= flush_pc_i;
  end

  // Continuous-stall counter saturates; any free cycle restarts it.
  always_ff @(posedge clk) begin
    if (rst)                      cont_cnt <= 32'd0;
    else if (!stall_any)          cont_cnt <= 32'd0;
    else if (cont_cnt != '1)      cont_cnt <= cont_cnt + 32'd1;
  end

  // Watchdog flag rises on the edge where the run length reaches the limit and sticks until reset.
  always_ff @(posedge clk) begin
    if (rst)
      stall_timeout_o <= 1'b0;
    else if ((stall_any && (cont_cnt + 32'd1 >= STALL_LIMIT)) || (cont_cnt >= STALL_LIMIT))
      stall_timeout_o <= 1'b1;
  end

`ifdef PIPE_CTRL_STALL_CNT_EN
  // Lifetime stalled-cycle counter, free-running wrap-around.
  always_ff @(posedge clk) begin
    if (rst)            stall_cnt_o <= 32'd0;
    else if (stall_any) stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard testbench for pipe_ctrl
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_from_id;
  logic        stallreq_from_ex;
  logic        stallreq_from_mem;
  logic        flushreq_i;
  logic [31:0] flush_pc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        stall_timeout_o;
`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  int n_vec;
  int n_err;
  logic exp_to;

  typedef struct {
    logic        flush;
    logic [31:0] pc;
    logic        timeout;
  } exp_t;

  exp_t sb[$];

  pipe_ctrl #(.STALL_LIMIT(255)) dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_id  (stallreq_from_id),
    .stallreq_from_ex  (stallreq_from_ex),
    .stallreq_from_mem (stallreq_from_mem),
    .flushreq_i        (flushreq_i),
    .flush_pc_i        (flush_pc_i),
    .stall_o           (stall_o),
    .flush_o           (flush_o),
    .new_pc_o          (new_pc_o),
    .stall_timeout_o   (stall_timeout_o)
`ifdef PIPE_CTRL_STALL_CNT_EN
    ,
    .stall_cnt_o       (stall_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive requests, check the combinational stall vector mid-cycle,
  // push what the registered outputs must be after the edge, then pop and compare.
  task automatic cycle(input logic r, input logic id, input logic ex, input logic mem,
                       input logic fr, input logic [31:0] pc, input logic [5:0] es,
                       input logic ef, input logic [31:0] epc);
    exp_t e;
    rst = r; stallreq_from_id = id; stallreq_from_ex = ex; stallreq_from_mem = mem;
    flushreq_i = fr; flush_pc_i = pc;
    @(negedge clk);
    check("stall_o", {26'd0, stall_o}, {26'd0, es});
    e.flush = ef; e.pc = epc; e.timeout = exp_to;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("flush_o", {31'd0, flush_o}, {31'd0, e.flush});
    check("new_pc_o", new_pc_o, e.pc);
    check("stall_timeout_o", {31'd0, stall_timeout_o}, {31'd0, e.timeout});
  endtask

  initial begin
    n_vec = 0; n_err = 0; exp_to = 1'b0;
    rst = 1'b1; stallreq_from_id = 0; stallreq_from_ex = 0; stallreq_from_mem = 0;
    flushreq_i = 0; flush_pc_i = 32'h0;
    @(posedge clk); #1;

    // reset holds stall low even with every request up
    cycle(1, 1, 1, 1, 1, 32'h44, 6'b000000, 0, 32'h0);
`ifdef PIPE_CTRL_STALL_CNT_EN
    check("stall_cnt_rst", stall_cnt_o, 32'd0);
`endif
    // stall priority patterns
    cycle(0, 0, 1, 0, 0, 32'h0, 6'b001111, 0, 32'h0);
    cycle(0, 0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0);
    cycle(0, 1, 0, 1, 0, 32'h0, 6'b011111, 0, 32'h0);
    cycle(0, 1, 0, 0, 0, 32'h0, 6'b000111, 0, 32'h0);
    cycle(0, 1, 1, 0, 0, 32'h0, 6'b001111, 0, 32'h0);
    // flush accepted alongside a stall; stall still applies this cycle
    cycle(0, 0, 1, 0, 1, 32'h40, 6'b001111, 1, 32'h40);
    // FLUSH cycle suppresses stall
    cycle(0, 0, 0, 1, 0, 32'h0, 6'b000000, 0, 32'h40);
    cycle(0, 0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'h40);
    // flush held 3 cycles: middle request lands in FLUSH and is dropped
    cycle(0, 0, 0, 0, 1, 32'h40, 6'b000000, 1, 32'h40);
    cycle(0, 0, 0, 0, 1, 32'h80, 6'b000000, 0, 32'h40);
    cycle(0, 0, 0, 0, 1, 32'hC0, 6'b000000, 1, 32'hC0);
    cycle(0, 0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'hC0);
    // reset during FLUSH aborts it
    cycle(0, 0, 0, 0, 1, 32'h100, 6'b000000, 1, 32'h100);
    cycle(1, 0, 0, 1, 1, 32'h200, 6'b000000, 0, 32'h0);
    cycle(0, 0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0);

    // a free cycle restarts the run length: 200 + 100 stalls never time out
    for (int i = 0; i < 200; i++) cycle(0, 0, 0, 1, 0, 32'h0, 6'b011111, 0, 32'h0);
    cycle(0, 0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0);
    for (int i = 0; i < 100; i++) cycle(0, 0, 0, 1, 0, 32'h0, 6'b011111, 0, 32'h0);
    cycle(0, 0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0);

    // 255 continuous stalls set the sticky flag exactly at the 255th edge
    for (int i = 0; i < 255; i++) begin
      exp_to = (i == 254);
      cycle(0, 0, 0, 1, 0, 32'h0, 6'b011111, 0, 32'h0);
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0);
    exp_to = 1'b0;
    cycle(1, 0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0);

`ifdef PIPE_CTRL_STALL_CNT_EN
    // total-stall counter: 10 stalled, 5 free, 3 stalled
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0, 0, 32'h0, 6'b001111, 0, 32'h0);
    for (int i = 0; i < 5; i++)  cycle(0, 0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0);
    for (int i = 0; i < 3; i++)  cycle(0, 1, 0, 0, 0, 32'h0, 6'b000111, 0, 32'h0);
    check("stall_cnt_13", stall_cnt_o, 32'd13);
    cycle(1, 0, 0, 0, 0, 32'h0, 6'b000000, 0, 32'h0);
    check("stall_cnt_clr", stall_cnt_o, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
